// File: rtl/lsu_axi_master.sv
// lsu_axi_master: bridges a single-outstanding core load/store request onto a
// 64-bit AXI-lite data port. Stores are lane-shifted with byte strobes; loads
// are lane-extracted and sign/zero-extended on the way back.
module lsu_axi_master (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        axi_aw_valid,
  input  logic        axi_aw_ready,
  output logic [31:0] axi_aw_addr,
  output logic [2:0]  axi_aw_prot,
  output logic        axi_w_valid,
  input  logic        axi_w_ready,
  output logic [63:0] axi_w_data,
  output logic [7:0]  axi_w_strb,
  input  logic        axi_b_valid,
  output logic        axi_b_ready,
  input  logic [1:0]  axi_b_resp,
  output logic        axi_ar_valid,
  input  logic        axi_ar_ready,
  output logic [31:0] axi_ar_addr,
  output logic [2:0]  axi_ar_prot,
  input  logic        axi_r_valid,
  output logic        axi_r_ready,
  input  logic [63:0] axi_r_data,
  input  logic [1:0]  axi_r_resp
);
  typedef enum logic [2:0] {S_IDLE, S_RD_AR, S_RD_R, S_WR, S_WR_B, S_ERR, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        ar_valid_q, ar_valid_d, r_ready_q, r_ready_d;
  logic        aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, b_ready_q, b_ready_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [63:0] w_data_q, w_data_d;
  logic [7:0]  w_strb_q, w_strb_d;
  logic [2:0]  sh_q, sh_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;

  logic [7:0]  size_bytes;
  logic [63:0] data_mask;
  logic        misaligned;
  logic [63:0] raw;
  logic [63:0] ld_data;

  // Request decode: byte-enable pattern, data mask and alignment of the incoming access
  always_comb begin
    size_bytes = 8'hFF;
    data_mask  = '1;
    misaligned = |req_addr[2:0];
    case (req_size)
      2'd0: begin size_bytes = 8'h01; data_mask = 64'h0000_0000_0000_00FF; misaligned = 1'b0; end
      2'd1: begin size_bytes = 8'h03; data_mask = 64'h0000_0000_0000_FFFF; misaligned = req_addr[0]; end
      2'd2: begin size_bytes = 8'h0F; data_mask = 64'h0000_0000_FFFF_FFFF; misaligned = |req_addr[1:0]; end
      default: ;
    endcase
  end

  // Load return path: shift the addressed lane down, then extend to 64 bits
  always_comb begin
    raw = axi_r_data >> {sh_q, 3'b000};
    case (size_q)
      2'd0:    ld_data = {{56{~uns_q & raw[7]}},  raw[7:0]};
      2'd1:    ld_data = {{48{~uns_q & raw[15]}}, raw[15:0]};
      2'd2:    ld_data = {{32{~uns_q & raw[31]}}, raw[31:0]};
      default: ld_data = raw;
    endcase
  end

  // Next-state and next-output logic; every bus-facing output is registered
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    ar_valid_d  = ar_valid_q;
    r_ready_d   = r_ready_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    b_ready_d   = b_ready_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    addr_d      = addr_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    sh_d        = sh_q;
    size_d      = size_q;
    uns_d       = uns_q;
    case (state_q)
      S_IDLE: if (req_valid && req_ready_q) begin
        addr_d      = {req_addr[31:3], 3'b000};
        sh_d        = req_addr[2:0];
        size_d      = req_size;
        uns_d       = req_unsigned;
        req_ready_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        if (misaligned) begin
          state_d = S_ERR;
        end else if (req_wen) begin
          state_d    = S_WR;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          w_data_d   = (req_wdata & data_mask) << {req_addr[2:0], 3'b000};
          w_strb_d   = size_bytes << req_addr[2:0];
        end else begin
          state_d    = S_RD_AR;
          ar_valid_d = 1'b1;
        end
      end
      S_RD_AR: if (axi_ar_ready) begin
        ar_valid_d = 1'b0;
        r_ready_d  = 1'b1;
        state_d    = S_RD_R;
      end
      S_RD_R: if (axi_r_valid) begin
        r_ready_d   = 1'b0;
        rsp_rdata_d = ld_data;
        rsp_err_d   = |axi_r_resp;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_WR: begin
        // AW and W retire independently; move on once neither is pending
        if (aw_valid_q && axi_aw_ready) aw_valid_d = 1'b0;
        if (w_valid_q && axi_w_ready)   w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) begin
          b_ready_d = 1'b1;
          state_d   = S_WR_B;
        end
      end
      S_WR_B: if (axi_b_valid) begin
        b_ready_d   = 1'b0;
        rsp_err_d   = |axi_b_resp;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_ERR: begin
        rsp_err_d   = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      sh_q        <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      b_ready_q   <= b_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      addr_q      <= addr_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      sh_q        <= sh_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign axi_aw_valid = aw_valid_q;
  assign axi_aw_addr  = addr_q;
  assign axi_aw_prot  = 3'b000;
  assign axi_w_valid  = w_valid_q;
  assign axi_w_data   = w_data_q;
  assign axi_w_strb   = w_strb_q;
  assign axi_b_ready  = b_ready_q;
  assign axi_ar_valid = ar_valid_q;
  assign axi_ar_addr  = addr_q;
  assign axi_ar_prot  = 3'b000;
  assign axi_r_ready  = r_ready_q;
endmodule
